// File: rtl/sync_fifo_param_pkg.sv
// rtl/sync_fifo_param_pkg.sv - shared FIFO constants, status struct and read-mode enum
package fifo_pkg;

  localparam int DATASIZE_DEF = 8;
  localparam int ADDRSIZE_DEF = 9;

  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
    logic overflow;
    logic underflow;
  } fifo_status_t;

  typedef enum logic {
    FWFT_STD  = 1'b0,
    FWFT_FALL = 1'b1
  } fifo_mode_e;

endpackage

// File: rtl/sync_fifo_param_if.sv
// rtl/sync_fifo_param_if.sv - producer/consumer handshake and status bundle for the FIFO
interface sync_fifo_param_if #(
  parameter int DATASIZE = 8,
  parameter int ADDRSIZE = 9
);
  logic                w_en;
  logic [DATASIZE-1:0] w_data;
  logic                r_en;
  logic [DATASIZE-1:0] r_data;
  logic                r_valid;
  logic                full;
  logic                empty;
  logic                almost_full;
  logic                almost_empty;
  logic [ADDRSIZE:0]   count;
  logic                err_clr;
  logic                overflow;
  logic                underflow;

  modport master (
    output w_en, w_data, r_en, err_clr,
    input  r_data, r_valid, full, empty, almost_full, almost_empty, count, overflow, underflow
  );

  modport slave (
    input  w_en, w_data, r_en, err_clr,
    output r_data, r_valid, full, empty, almost_full, almost_empty, count, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_param_mem.sv
// rtl/sync_fifo_param_mem.sv - DEPTH x DATASIZE two-port array; read port registered or combinational
module fifo_mem_2p #(
  parameter int DATASIZE = 8,
  parameter int ADDRSIZE = 9,
  parameter int FWFT     = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                we,
  input  logic [ADDRSIZE-1:0] waddr,
  input  logic [DATASIZE-1:0] wdata,
  input  logic                re,
  input  logic [ADDRSIZE-1:0] raddr,
  output logic [DATASIZE-1:0] rdata
);

  logic [DATASIZE-1:0] mem [2**ADDRSIZE];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // Head word is visible as soon as it is stored; read strobe and reset are not needed here.
      logic unused_ok;
      assign unused_ok = &{1'b0, rst, re};
      assign rdata = mem[raddr];
    end else begin : g_reg
      always_ff @(posedge clk) begin
        if (rst)     rdata <= '0;
        else if (re) rdata <= mem[raddr];
      end
    end
  endgenerate

endmodule

// File: rtl/sync_fifo_param.sv
// rtl/sync_fifo_param.sv - single-clock FIFO with occupancy, thresholds, FWFT option and sticky errors
module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter int DATASIZE = DATASIZE_DEF,
  parameter int ADDRSIZE = ADDRSIZE_DEF,
  parameter int AF_LEVEL = (1 << ADDRSIZE) - 4,
  parameter int AE_LEVEL = 4,
  parameter int FWFT     = 0
) (
  input logic              w_clk,
  input logic              w_rst,
  sync_fifo_param_if.slave bus
);

  localparam int DEPTH = 1 << ADDRSIZE;
  localparam logic [ADDRSIZE:0] AF_CNT = (ADDRSIZE+1)'(AF_LEVEL);
  localparam logic [ADDRSIZE:0] AE_CNT = (ADDRSIZE+1)'(AE_LEVEL);

  generate
    if (!(AE_LEVEL < AF_LEVEL && AF_LEVEL <= DEPTH)) begin : g_bad_levels
      $error("sync_fifo_param: need AE_LEVEL < AF_LEVEL <= DEPTH");
    end
    if (DATASIZE < 1) begin : g_bad_width
      $error("sync_fifo_param: DATASIZE must be at least 1");
    end
  endgenerate

  logic [ADDRSIZE:0] wptr, rptr, cnt;
  logic              ovf_q, udf_q, rvalid_q;
  logic              wr_ok, rd_ok;
  fifo_status_t      st;

  // Flags come only from registered pointers/count so no request input reaches them combinationally.
  always_comb begin
    st              = '0;
    st.full         = (wptr[ADDRSIZE-1:0] == rptr[ADDRSIZE-1:0]) && (wptr[ADDRSIZE] != rptr[ADDRSIZE]);
    st.empty        = (wptr == rptr);
    st.almost_full  = (cnt >= AF_CNT);
    st.almost_empty = (cnt <= AE_CNT);
    st.overflow     = ovf_q;
    st.underflow    = udf_q;
  end

  assign wr_ok = bus.w_en && !st.full;
  assign rd_ok = bus.r_en && !st.empty;

  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      wptr     <= '0;
      rptr     <= '0;
      cnt      <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
      rvalid_q <= 1'b0;
    end else begin
      if (wr_ok) wptr <= wptr + 1'b1;
      if (rd_ok) rptr <= rptr + 1'b1;
      case ({wr_ok, rd_ok})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
      // A new error in the same cycle as err_clr keeps the flag set.
      if (bus.w_en && st.full) ovf_q <= 1'b1;
      else if (bus.err_clr)    ovf_q <= 1'b0;
      if (bus.r_en && st.empty) udf_q <= 1'b1;
      else if (bus.err_clr)     udf_q <= 1'b0;
      rvalid_q <= rd_ok;
    end
  end

  fifo_mem_2p #(
    .DATASIZE (DATASIZE),
    .ADDRSIZE (ADDRSIZE),
    .FWFT     (FWFT)
  ) u_mem (
    .clk   (w_clk),
    .rst   (w_rst),
    .we    (wr_ok),
    .waddr (wptr[ADDRSIZE-1:0]),
    .wdata (bus.w_data),
    .re    (rd_ok),
    .raddr (rptr[ADDRSIZE-1:0]),
    .rdata (bus.r_data)
  );

  generate
    if (FWFT != 0) begin : g_rv_fwft
      logic unused_rv;
      assign unused_rv   = rvalid_q;
      assign bus.r_valid = !st.empty;
    end else begin : g_rv_std
      assign bus.r_valid = rvalid_q;
    end
  endgenerate

  assign bus.full         = st.full;
  assign bus.empty        = st.empty;
  assign bus.almost_full  = st.almost_full;
  assign bus.almost_empty = st.almost_empty;
  assign bus.overflow     = st.overflow;
  assign bus.underflow    = st.underflow;
  assign bus.count        = cnt;

endmodule

// File: tb/tb_sync_fifo_param.sv
// tb/tb_sync_fifo_param.sv - randomized queue-model bench driving standard and FWFT FIFOs in lockstep
module tb_sync_fifo_param;

  localparam int DEPTH = 16;
  localparam int AF    = 14;
  localparam int AE    = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       w_en = 1'b0, r_en = 1'b0, err_clr = 1'b0;
  logic [7:0] w_data = 8'h00;

  always #5 clk = ~clk;

  sync_fifo_param_if #(.DATASIZE(8), .ADDRSIZE(4)) if_std ();
  sync_fifo_param_if #(.DATASIZE(8), .ADDRSIZE(4)) if_ft ();

  assign if_std.w_en = w_en;  assign if_std.w_data = w_data;
  assign if_std.r_en = r_en;  assign if_std.err_clr = err_clr;
  assign if_ft.w_en  = w_en;  assign if_ft.w_data  = w_data;
  assign if_ft.r_en  = r_en;  assign if_ft.err_clr  = err_clr;

  sync_fifo_param #(.DATASIZE(8), .ADDRSIZE(4), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(0)) u_std (
    .w_clk (clk), .w_rst (rst), .bus (if_std)
  );
  sync_fifo_param #(.DATASIZE(8), .ADDRSIZE(4), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(1)) u_ft (
    .w_clk (clk), .w_rst (rst), .bus (if_ft)
  );

  int         total = 0;
  int         bad   = 0;
  logic [7:0] q[$];
  logic       m_ovf = 1'b0, m_udf = 1'b0, m_rv = 1'b0;
  logic [7:0] m_rd  = 8'h00;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    int n = q.size();
    check("std_count", 32'(if_std.count), n);
    check("ft_count",  32'(if_ft.count),  n);
    check("std_full",  32'(if_std.full),  32'(n == DEPTH));
    check("ft_full",   32'(if_ft.full),   32'(n == DEPTH));
    check("std_empty", 32'(if_std.empty), 32'(n == 0));
    check("ft_empty",  32'(if_ft.empty),  32'(n == 0));
    check("std_afull", 32'(if_std.almost_full),  32'(n >= AF));
    check("ft_afull",  32'(if_ft.almost_full),   32'(n >= AF));
    check("std_aempty", 32'(if_std.almost_empty), 32'(n <= AE));
    check("ft_aempty",  32'(if_ft.almost_empty),  32'(n <= AE));
    check("std_ovf", 32'(if_std.overflow),  32'(m_ovf));
    check("ft_ovf",  32'(if_ft.overflow),   32'(m_ovf));
    check("std_udf", 32'(if_std.underflow), 32'(m_udf));
    check("ft_udf",  32'(if_ft.underflow),  32'(m_udf));
    check("std_rvalid", 32'(if_std.r_valid), 32'(m_rv));
    check("std_rdata",  32'(if_std.r_data),  32'(m_rd));
    check("ft_rvalid",  32'(if_ft.r_valid),  32'(n != 0));
    if (n != 0) check("ft_rdata", 32'(if_ft.r_data), 32'(q[0]));
  endtask

  // One clock: drive, let the edge happen, advance the queue model, compare.
  task automatic step(input logic we, input logic [7:0] wd, input logic re,
                      input logic ec, input logic rs);
    logic       was_full, was_empty, wr_ok, rd_ok;
    logic [7:0] head;
    w_en = we; w_data = wd; r_en = re; err_clr = ec; rst = rs;
    @(posedge clk);
    #1;
    if (rs) begin
      q.delete();
      m_ovf = 1'b0; m_udf = 1'b0; m_rv = 1'b0; m_rd = 8'h00;
    end else begin
      was_full  = (q.size() == DEPTH);
      was_empty = (q.size() == 0);
      wr_ok = we && !was_full;
      rd_ok = re && !was_empty;
      m_rv  = rd_ok;
      if (rd_ok) begin
        head = q.pop_front();
        m_rd = head;
      end
      if (wr_ok) q.push_back(wd);
      if (we && was_full) m_ovf = 1'b1; else if (ec) m_ovf = 1'b0;
      if (re && was_empty) m_udf = 1'b1; else if (ec) m_udf = 1'b0;
    end
    check_all();
  endtask

  initial begin
    step(0, 8'h00, 0, 0, 1);
    step(0, 8'h00, 0, 0, 0);

    for (int i = 0; i < 16; i++) step(1, 8'(i), 0, 0, 0);
    step(1, 8'hEE, 0, 0, 0);
    for (int i = 0; i < 16; i++) step(0, 8'h00, 1, 0, 0);
    step(0, 8'h00, 0, 1, 0);

    for (int i = 0; i < 8; i++) step(1, 8'($urandom), 0, 0, 0);
    for (int i = 0; i < 40; i++) step(1, 8'($urandom), 1, 0, 0);
    while (q.size() != 0) step(0, 8'h00, 1, 0, 0);

    step(0, 8'h00, 1, 0, 0);
    step(0, 8'h00, 1, 1, 0);
    step(0, 8'h00, 0, 1, 0);

    step(1, 8'hA5, 0, 0, 0);
    step(0, 8'h00, 1, 0, 0);

    for (int i = 0; i < 9; i++) step(1, 8'(8'h40 + i), 0, 0, 0);
    step(0, 8'h00, 1, 0, 0);
    step(0, 8'h00, 0, 0, 1);
    step(1, 8'h5C, 0, 0, 0);
    step(0, 8'h00, 1, 0, 0);
    step(0, 8'h00, 0, 0, 0);

    for (int i = 0; i < 600; i++) begin
      int mode = (i / 100) % 3;
      logic we = ($urandom_range(0, 9) < (mode == 0 ? 7 : (mode == 1 ? 3 : 5)));
      logic re = ($urandom_range(0, 9) < (mode == 0 ? 3 : (mode == 1 ? 7 : 5)));
      step(we, 8'($urandom), re, $urandom_range(0, 15) == 0, $urandom_range(0, 199) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
